// File: rtl/reset_sequencer.sv
// reset_sequencer: turns the system reset (or an accepted soft-reset request)
// into staged, ordered reset releases for NUM_STAGES downstream domains.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high system reset (highest priority)
//   soft_rst_req  level request to re-run the reset sequence, sampled in RUN only
//   soft_rst_ack  one-cycle pulse when a soft request is accepted
//   rst_out       active-high per-stage resets, released lowest index first
//   ready         high once every stage is released
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_rst_req,
    output logic                  soft_rst_ack,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready
);

    // Stage index must be able to reach NUM_STAGES ("all released").
    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;  // edges spent in the current hold/gap interval
    logic [IDX_W-1:0]   idx;  // number of stages already released

    // Sequencer: counters reload on each transition and never run past their
    // terminal count, since the transition happens exactly at that count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ASSERT;
            cnt          <= '0;
            idx          <= '0;
            rst_out      <= '1;
            ready        <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            soft_rst_ack <= 1'b0;
            unique case (state)
                ASSERT: begin
                    // This edge is E0; it counts as the first hold cycle.
                    state <= HOLD;
                    cnt   <= CNT_W'(1);
                end
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYCLES)) begin
                        state   <= RELEASE;
                        rst_out <= rst_out << 1;  // release stage 0
                        idx     <= IDX_W'(1);
                        cnt     <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (idx == IDX_W'(NUM_STAGES)) begin
                        state <= RUN;
                        ready <= 1'b1;
                        cnt   <= '0;
                        idx   <= '0;
                    end else if (cnt == CNT_W'(STAGE_GAP)) begin
                        // Shifting zeros in from the bottom releases the
                        // next-lowest stage still held.
                        rst_out <= rst_out << 1;
                        idx     <= idx + IDX_W'(1);
                        cnt     <= CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (soft_rst_req) begin
                        // Accept edge behaves exactly like E0.
                        state        <= HOLD;
                        soft_rst_ack <= 1'b1;
                        rst_out      <= '1;
                        ready        <= 1'b0;
                        cnt          <= CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int unsigned N1 = 4, H1 = 16, G1 = 8;
    localparam int unsigned N2 = 1, H2 = 1,  G2 = 1;
    localparam int RDY1 = H1 + (N1 - 1) * G1 + 1;
    localparam int RDY2 = H2 + (N2 - 1) * G2 + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic soft_rst_req = 1'b0;

    logic [N1-1:0] rst_out1;
    logic          ready1, ack1;
    logic [N2-1:0] rst_out2;
    logic          ready2, ack2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(N1), .HOLD_CYCLES(H1), .STAGE_GAP(G1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
        .soft_rst_ack(ack1), .rst_out(rst_out1), .ready(ready1)
    );

    reset_sequencer #(.NUM_STAGES(N2), .HOLD_CYCLES(H2), .STAGE_GAP(G2), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
        .soft_rst_ack(ack2), .rst_out(rst_out2), .ready(ready2)
    );

    // Timeline model: t = edges since the last trigger edge (E0 or accept edge).
    // Stage k is held while t < H + k*G; ready once t >= H + (N-1)*G + 1.
    // A request is only accepted when the pre-edge timeline is already ready.
    int      t1 = 0, t2 = 0;
    bit      inr1 = 1'b1, inr2 = 1'b1;
    logic [N1-1:0] e_rst1 = '1;
    logic [N2-1:0] e_rst2 = '1;
    logic    e_rdy1 = 1'b0, e_ack1 = 1'b0;
    logic    e_rdy2 = 1'b0, e_ack2 = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            inr1 = 1'b1; e_ack1 = 1'b0;
        end else if (inr1) begin
            inr1 = 1'b0; t1 = 0; e_ack1 = 1'b0;
        end else if (t1 >= RDY1 && soft_rst_req) begin
            t1 = 0; e_ack1 = 1'b1;
        end else begin
            e_ack1 = 1'b0;
            if (t1 < 100000) t1++;
        end
        for (int k = 0; k < N1; k++) e_rst1[k] = inr1 || (t1 < int'(H1 + k * G1));
        e_rdy1 = !inr1 && (t1 >= RDY1);
    end

    always @(posedge clk) begin
        if (reset) begin
            inr2 = 1'b1; e_ack2 = 1'b0;
        end else if (inr2) begin
            inr2 = 1'b0; t2 = 0; e_ack2 = 1'b0;
        end else if (t2 >= RDY2 && soft_rst_req) begin
            t2 = 0; e_ack2 = 1'b1;
        end else begin
            e_ack2 = 1'b0;
            if (t2 < 100000) t2++;
        end
        for (int k = 0; k < N2; k++) e_rst2[k] = inr2 || (t2 < int'(H2 + k * G2));
        e_rdy2 = !inr2 && (t2 >= RDY2);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; soft_rst_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (rst_out1 !== 4'hF || ready1 !== 1'b0 || ack1 !== 1'b0) begin
                bad++; $display("FAIL reset_hold rst=%h rdy=%b ack=%b want F/0/0", rst_out1, ready1, ack1);
            end
        end
        reset = 1'b0;
        for (int j = 0; j <= 45; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL reset_seq j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            total++;
            if (rst_out2 !== e_rst2 || ready2 !== e_rdy2 || ack2 !== e_ack2) begin
                bad++; $display("FAIL reset_seq2 j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out2, e_rst2, ready2, e_rdy2, ack2, e_ack2);
            end
            if (j == 15 || j == 16 || j == 24 || j == 32 || j == 40) begin
                logic [3:0] want;
                want = (j == 15) ? 4'hF : (j == 16) ? 4'hE : (j == 24) ? 4'hC : (j == 32) ? 4'h8 : 4'h0;
                total++;
                if (rst_out1 !== want) begin
                    bad++; $display("FAIL reset_stage j=%0d rst=%h want %h", j, rst_out1, want);
                end
            end
            if (j == 40 || j == 41) begin
                total++;
                if (ready1 !== (j == 41)) begin
                    bad++; $display("FAIL reset_ready j=%0d rdy=%b want %b", j, ready1, (j == 41));
                end
            end
        end
    endtask

    task automatic test_soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++;
        if (ack1 !== 1'b1 || rst_out1 !== 4'hF || ready1 !== 1'b0) begin
            bad++; $display("FAIL soft_accept ack=%b rst=%h rdy=%b want 1/F/0", ack1, rst_out1, ready1);
        end
        for (int j = 1; j <= 45; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL soft_seq j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            total++;
            if (rst_out2 !== e_rst2 || ready2 !== e_rdy2 || ack2 !== e_ack2) begin
                bad++; $display("FAIL soft_seq2 j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out2, e_rst2, ready2, e_rdy2, ack2, e_ack2);
            end
            if (j == 1 || j == 16 || j == 41) begin
                total++;
                if ((j == 1 && ack1 !== 1'b0) || (j == 16 && rst_out1 !== 4'hE) || (j == 41 && ready1 !== 1'b1)) begin
                    bad++; $display("FAIL soft_point j=%0d ack=%b rst=%h rdy=%b", j, ack1, rst_out1, ready1);
                end
            end
        end
    endtask

    task automatic test_req_during_release();
        int rise_j, ack_j;
        logic prev_rdy;
        rise_j = -1; ack_j = -1; prev_rdy = 1'b0;
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int j = 0; j < 100 && ack_j < 0; j++) begin
            if (j == 20) soft_rst_req = 1'b1;
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL relreq_seq j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            if (ready1 === 1'b1 && !prev_rdy) rise_j = j;
            prev_rdy = ready1;
            if (ack1 === 1'b1) ack_j = j;
        end
        soft_rst_req = 1'b0;
        total++;
        if (ack_j != 42 || rise_j != 41) begin
            bad++; $display("FAIL relreq_timing ready_rise=%0d ack=%0d want 41/42", rise_j, ack_j);
        end
        for (int j = 0; j < 45; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL relreq_after j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int j = 0; j < 28; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL mid_pre j=%0d rst=%h/%h rdy=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1);
            end
        end
        total++;
        if (rst_out1 !== 4'hC) begin
            bad++; $display("FAIL mid_partial rst=%h want c", rst_out1);
        end
        reset = 1'b1; soft_rst_req = 1'b1;
        tick();
        total++;
        if (rst_out1 !== 4'hF || ready1 !== 1'b0 || ack1 !== 1'b0) begin
            bad++; $display("FAIL mid_reset rst=%h rdy=%b ack=%b want F/0/0", rst_out1, ready1, ack1);
        end
        reset = 1'b0; soft_rst_req = 1'b0;
        for (int j = 0; j <= 45; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL mid_post j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            if (j == 40 || j == 41) begin
                total++;
                if (ready1 !== (j == 41)) begin
                    bad++; $display("FAIL mid_ready j=%0d rdy=%b", j, ready1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks, last, rdy_cnt;
        acks = 0; last = -1; rdy_cnt = 0;
        soft_rst_req = 1'b1;
        for (int j = 0; j < 140; j++) begin
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL b2b_seq j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            if (ready1 === 1'b1) rdy_cnt++;
            if (ack1 === 1'b1) begin
                if (last >= 0) begin
                    total++;
                    if (j - last != 42 || rdy_cnt != 1) begin
                        bad++; $display("FAIL b2b_gap gap=%0d ready_cycles=%0d want 42/1", j - last, rdy_cnt);
                    end
                end
                last = j; acks++; rdy_cnt = 0;
            end
        end
        soft_rst_req = 1'b0;
        total++;
        if (acks != 4) begin
            bad++; $display("FAIL b2b_count acks=%0d want 4", acks);
        end
        for (int j = 0; j < 45; j++) tick();
    endtask

    task automatic test_single_stage();
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            total++;
            if (rst_out2 !== e_rst2 || ready2 !== e_rdy2 || ack2 !== e_ack2) begin
                bad++; $display("FAIL single_seq j=%0d rst=%b/%b rdy=%b/%b", j, rst_out2, e_rst2, ready2, e_rdy2);
            end
            total++;
            if (rst_out2 !== (j < 1) || ready2 !== (j >= 2)) begin
                bad++; $display("FAIL single_point j=%0d rst=%b rdy=%b want %b/%b", j, rst_out2, ready2, (j < 1), (j >= 2));
            end
        end
        for (int j = 0; j < 45; j++) tick();
    endtask

    task automatic test_random();
        for (int j = 0; j < 800; j++) begin
            if ($urandom_range(0, 5) == 0) soft_rst_req = ~soft_rst_req;
            reset = ($urandom_range(0, 149) == 0);
            tick();
            total++;
            if (rst_out1 !== e_rst1 || ready1 !== e_rdy1 || ack1 !== e_ack1) begin
                bad++; $display("FAIL rand_seq j=%0d rst=%h/%h rdy=%b/%b ack=%b/%b", j, rst_out1, e_rst1, ready1, e_rdy1, ack1, e_ack1);
            end
            total++;
            if (rst_out2 !== e_rst2 || ready2 !== e_rdy2 || ack2 !== e_ack2) begin
                bad++; $display("FAIL rand_seq2 j=%0d rst=%b/%b rdy=%b/%b ack=%b/%b", j, rst_out2, e_rst2, ready2, e_rdy2, ack2, e_ack2);
            end
        end
        reset = 1'b0; soft_rst_req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_soft_pulse();
        test_req_during_release();
        test_reset_mid();
        test_back_to_back();
        test_single_stage();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
